// File: rtl/valu_pkg.sv
// Shared definitions for the VALU write-back stage: control codes, lane geometry, FSM states.
package valu_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned DATA_W    = LANE_W * NUM_LANES;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned CTRL_W    = 3;
  localparam int unsigned CNT_W     = 5;

  localparam logic [CTRL_W-1:0] CTRL_VSUM = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_VSUB = 3'b110;
  localparam logic [CTRL_W-1:0] CTRL_VDP  = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/valu_wb_if.sv
// Upstream beat, downstream write-back and flush signals of the VALU write-back stage.
interface valu_wb_if;

  logic                            valid_i;
  logic                            ready_o;
  logic [valu_pkg::DATA_W-1:0]     v_i;
  logic [valu_pkg::NUM_LANES-1:0]  over_i;
  logic [valu_pkg::CTRL_W-1:0]     ctrl_i;
  logic                            acc_i;
  logic [valu_pkg::RD_W-1:0]       rd_i;
  logic                            flush_i;

  logic                            valid_o;
  logic                            ready_i;
  logic [valu_pkg::DATA_W-1:0]     wd_o;
  logic [valu_pkg::RD_W-1:0]       rd_o;
  logic [valu_pkg::NUM_LANES-1:0]  sat_o;
  logic                            sat_sticky_o;

  modport slave (
    input  valid_i, v_i, over_i, ctrl_i, acc_i, rd_i, flush_i, ready_i,
    output ready_o, valid_o, wd_o, rd_o, sat_o, sat_sticky_o
  );

  modport master (
    output valid_i, v_i, over_i, ctrl_i, acc_i, rd_i, flush_i, ready_i,
    input  ready_o, valid_o, wd_o, rd_o, sat_o, sat_sticky_o
  );

endinterface

// File: rtl/valu_lane_sat.sv
// One 8-bit lane: clamp to +127 when the result must be non-negative but came out negative.
module valu_lane_sat
  import valu_pkg::*;
(
  input  logic [LANE_W-1:0] lane_i,
  input  logic              over_i,
  input  logic              en_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              sat_o
);

  assign sat_o  = en_i && over_i && lane_i[LANE_W-1];
  assign lane_o = sat_o ? {1'b0, {(LANE_W-1){1'b1}}} : lane_i;

endmodule

// File: rtl/valu_wb.sv
// VALU write-back stage: per-lane saturation for VSUM/VSUB, VDP dot-product accumulation,
// single-entry output register with valid/ready handshake.
module valu_wb
  import valu_pkg::*;
#(
  parameter int unsigned        ACC_LEN = 4,
  parameter logic [CTRL_W-1:0]  VSUM    = CTRL_VSUM,
  parameter logic [CTRL_W-1:0]  VSUB    = CTRL_VSUB,
  parameter logic [CTRL_W-1:0]  VDP     = CTRL_VDP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  valu_wb_if.slave   bus
);

  localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);

  wb_state_e              state_q, state_d;
  logic [DATA_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [RD_W-1:0]        rd_q, rd_d;
  logic [NUM_LANES-1:0]   sat_q, sat_d;
  logic                   sticky_q, sticky_d;

  logic                   is_sum_sub;
  logic                   is_acc_beat;
  logic                   accept;
  logic [CNT_W-1:0]       cnt_inc;
  logic [DATA_W-1:0]      acc_sum;
  logic [DATA_W-1:0]      sat_data;
  logic [NUM_LANES-1:0]   sat_vec;

  assign is_sum_sub  = (bus.ctrl_i == VSUM) || (bus.ctrl_i == VSUB);
  assign is_acc_beat = (bus.ctrl_i == VDP) && bus.acc_i;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign acc_sum     = acc_q + bus.v_i;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    valu_lane_sat u_lane_sat (
      .lane_i (bus.v_i[k*LANE_W +: LANE_W]),
      .over_i (bus.over_i[k]),
      .en_i   (is_sum_sub),
      .lane_o (sat_data[k*LANE_W +: LANE_W]),
      .sat_o  (sat_vec[k])
    );
  end

  // While a group is open, only further accumulate beats may enter.
  assign bus.ready_o = (!valid_q || bus.ready_i) && !bus.flush_i
                       && !((state_q == ST_ACC) && bus.valid_i && !is_acc_beat);
  assign accept      = bus.valid_i && bus.ready_o;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    wd_d     = wd_q;
    rd_d     = rd_q;
    sat_d    = sat_q;
    sticky_d = sticky_q;

    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end

    if (bus.flush_i) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept) begin
      if (is_acc_beat) begin
        if (state_q == ST_IDLE) begin
          state_d = ST_ACC;
          acc_d   = bus.v_i;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc == ACC_LEN_C) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
          wd_d    = acc_sum;
          rd_d    = bus.rd_i;
          sat_d   = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
        end
      end else begin
        valid_d  = 1'b1;
        wd_d     = sat_data;
        rd_d     = bus.rd_i;
        sat_d    = sat_vec;
        sticky_d = sticky_q | (|sat_vec);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      wd_q     <= '0;
      rd_q     <= '0;
      sat_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      wd_q     <= wd_d;
      rd_q     <= rd_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.wd_o         = wd_q;
  assign bus.rd_o         = rd_q;
  assign bus.sat_o        = sat_q;
  assign bus.sat_sticky_o = sticky_q;

endmodule
